// File: rtl/lsu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lsu_pkg : shared funct3 codes, FSM states and helpers for lsu_ctrl |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
    if (we) begin
      return f3 > F3_W;
    end
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lsu_align : access checks, store lane steering, load extraction    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module lsu_align
  import lsu_pkg::*;
(
  input  logic            acc_we,
  input  logic [2:0]      acc_funct3,
  input  logic [1:0]      acc_off,
  input  logic [XLEN-1:0] acc_wdata,
  output logic            acc_err,
  output logic [3:0]      acc_be,
  output logic [XLEN-1:0] acc_lane_wdata,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_off,
  input  logic [XLEN-1:0] ld_word,
  output logic [XLEN-1:0] ld_data
);

  logic        w_misaligned;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // funct3[1:0] encodes the access size for both loads and stores
  always_comb begin
    w_misaligned = 1'b0;
    case (acc_funct3[1:0])
      2'b01:   w_misaligned = acc_off[0];
      2'b10:   w_misaligned = (acc_off != 2'b00);
      default: w_misaligned = 1'b0;
    endcase
    acc_err = w_misaligned | funct3_illegal(acc_we, acc_funct3);
  end

  always_comb begin
    acc_be         = 4'hF;
    acc_lane_wdata = '0;
    if (acc_we) begin
      case (acc_funct3)
        F3_B: begin
          acc_be         = 4'b0001 << acc_off;
          acc_lane_wdata = {4{acc_wdata[7:0]}};
        end
        F3_H: begin
          acc_be         = 4'b0011 << acc_off;
          acc_lane_wdata = {2{acc_wdata[15:0]}};
        end
        default: acc_lane_wdata = acc_wdata;
      endcase
    end
  end

  always_comb begin
    w_byte = ld_word[{ld_off, 3'b000} +: 8];
    w_half = ld_word[{ld_off[1], 4'b0000} +: 16];
    case (ld_funct3)
      F3_B:    ld_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    ld_data = {{16{w_half[15]}}, w_half};
      F3_BU:   ld_data = {24'h0, w_byte};
      F3_HU:   ld_data = {16'h0, w_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lsu_ctrl : RV32I load/store unit between execute and data memory   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module lsu_ctrl #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic [4:0]        resp_rd,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  import lsu_pkg::*;

  lsu_state_e        r_state;
  lsu_state_e        w_state_nxt;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [1:0]        r_off;
  logic [4:0]        r_rd;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [XLEN-1:0]   r_wdata;
  logic [XLEN-1:0]   r_rdata;
  logic              r_err;

  logic              w_accept;
  logic              w_acc_err;
  logic [3:0]        w_acc_be;
  logic [XLEN-1:0]   w_acc_wdata;
  logic [XLEN-1:0]   w_ld_data;

  assign w_accept = req_valid && (r_state == IDLE);

  lsu_align u_align (
    .acc_we         (req_we),
    .acc_funct3     (req_funct3),
    .acc_off        (req_addr[1:0]),
    .acc_wdata      (req_wdata),
    .acc_err        (w_acc_err),
    .acc_be         (w_acc_be),
    .acc_lane_wdata (w_acc_wdata),
    .ld_funct3      (r_funct3),
    .ld_off         (r_off),
    .ld_word        (mem_rdata),
    .ld_data        (w_ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_state_nxt = w_acc_err ? RESP : REQ;
      REQ:     if (mem_gnt) w_state_nxt = r_we ? RESP : WAIT;
      WAIT:    if (mem_rvalid) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Load data is cleared on accept so stores and errors return zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_off    <= 2'b00;
      r_rd     <= 5'd0;
      r_addr   <= '0;
      r_be     <= 4'h0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_we     <= req_we;
      r_funct3 <= req_funct3;
      r_off    <= req_addr[1:0];
      r_rd     <= req_rd;
      r_addr   <= {req_addr[ADDR_W-1:2], 2'b00};
      r_be     <= w_acc_be;
      r_wdata  <= w_acc_wdata;
      r_rdata  <= '0;
      r_err    <= w_acc_err;
    end else if ((r_state == WAIT) && mem_rvalid) begin
      r_rdata  <= w_ld_data;
    end
  end

  // Outputs decode registered state only; nothing flows through from inputs
  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = resp_valid ? r_rdata : '0;
  assign resp_rd    = (resp_valid && !r_we) ? r_rd : 5'd0;
  assign resp_err   = resp_valid & r_err;
  assign mem_req    = (r_state == REQ);
  assign mem_we     = mem_req & r_we;
  assign mem_addr   = mem_req ? r_addr : '0;
  assign mem_be     = mem_req ? r_be : 4'h0;
  assign mem_wdata  = mem_req ? r_wdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_lsu_ctrl : randomized bench for lsu_ctrl with a per-cycle model |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(32), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    bit          ready;
    bit          mreq;
    bit          mwe;
    logic [31:0] maddr;
    logic [3:0]  mbe;
    logic [31:0] mwdata;
    bit          chk_wdata;
    bit          rvalid;
    logic [31:0] rdata;
    logic [4:0]  rd;
    bit          err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_m [logic [31:0]];
  int          errors = 0;
  int          checks = 0;
  bit          chk_en = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          last_resp_cyc = 0;
  logic [31:0] last_rdata, last_mwdata, last_maddr;
  logic [4:0]  last_rd;
  logic [3:0]  last_mbe;
  logic        last_err;
  bit          saw_mreq = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    if (we) legal = (f3 <= 3'd2);
    else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 1'b1;
    return (a % acc_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input bit we, input logic [2:0] f3, input logic [31:0] a);
    if (!we) return 4'hF;
    return 4'(((1 << acc_size(f3)) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (acc_size(f3))
      1:       return {24'h0, d[7:0]} * 32'h01010101;
      2:       return {16'h0, d[15:0]} * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
    logic [31:0] v, mask;
    int sz;
    sz = acc_size(f3);
    v  = word >> (8 * (a % 4));
    if (sz < 4) begin
      mask = (32'h1 << (8 * sz)) - 32'h1;
      v = v & mask;
      if (!f3[2] && v[8*sz-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] wa);
    return mem_m.exists(wa) ? mem_m[wa] : 32'h0;
  endfunction

  function automatic exp_t idle_exp();
    exp_t e;
    e = '{default: 0};
    e.ready = 1'b1;
    return e;
  endfunction

  // One access: build its per-cycle expectation, then drive request and memory
  task automatic run_access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input logic [4:0] rd, input int g, input int r);
    exp_t        e;
    bit          err, in_req, in_wait;
    int          n;
    logic [31:0] wa, word, lanes;
    logic [3:0]  be;
    err  = m_err(we, f3, a);
    wa   = a & ~32'h3;
    word = mem_rd(wa);
    be   = m_be(we, f3, a);
    n    = err ? 1 : (we ? 2 + g : 3 + g + r);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d; req_rd = rd;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
    acc_cyc = cyc;
    exp_q.push_back(idle_exp());
    for (int k = 1; k <= n; k++) begin
      e = '{default: 0};
      e.mreq      = !err && (k <= 1 + g);
      e.mwe       = we;
      e.maddr     = wa;
      e.mbe       = be;
      e.mwdata    = m_wdata(f3, d);
      e.chk_wdata = we;
      e.rvalid    = (k == n);
      e.err       = err;
      e.rdata     = (k == n && !we && !err) ? m_load(f3, a, word) : 32'h0;
      e.rd        = we ? 5'd0 : rd;
      exp_q.push_back(e);
    end
    if (we && !err) begin
      lanes = m_wdata(f3, d);
      for (int i = 0; i < 4; i++) if (be[i]) word[8*i +: 8] = lanes[8*i +: 8];
      mem_m[wa] = word;
    end
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      req_valid  = (k < n) ? 1'($urandom) : 1'b0;
      req_we     = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom;
      req_wdata  = $urandom;     req_rd     = 5'($urandom);
      in_req     = !err && (k <= 1 + g);
      in_wait    = !err && !we && (k >= 2 + g) && (k <= 2 + g + r);
      mem_gnt    = in_req ? (k == 1 + g) : (in_wait ? 1'($urandom) : 1'b0);
      mem_rvalid = in_wait ? (k == 2 + g + r) : ((in_req && k < 1 + g) ? 1'($urandom) : 1'b0);
      mem_rdata  = (in_wait && k == 2 + g + r) ? mem_rd(wa) : $urandom;
    end
  endtask

  task automatic idle_cycles(input int m);
    repeat (m) begin
      @(posedge clk); #1;
      req_valid = 1'b0; mem_gnt = 1'($urandom); mem_rvalid = 1'($urandom); mem_rdata = $urandom;
    end
  endtask

  // ---------------- compare process ----------------
  initial begin : cmp
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (chk_en) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : idle_exp();
        check("req_ready", 32'(req_ready), 32'(e.ready));
        check("mem_req", 32'(mem_req), 32'(e.mreq));
        check("resp_valid", 32'(resp_valid), 32'(e.rvalid));
        if (e.mreq) begin
          check("mem_we", 32'(mem_we), 32'(e.mwe));
          check("mem_addr", mem_addr, e.maddr);
          check("mem_be", 32'(mem_be), 32'(e.mbe));
          if (e.chk_wdata) check("mem_wdata", mem_wdata, e.mwdata);
        end
        if (e.rvalid) begin
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_rd", 32'(resp_rd), 32'(e.rd));
          check("resp_err", 32'(resp_err), 32'(e.err));
        end
      end
      if (mem_req) begin
        saw_mreq = 1'b1; last_mbe = mem_be; last_mwdata = mem_wdata; last_maddr = mem_addr;
      end
      if (resp_valid) begin
        last_resp_cyc = cyc; last_rdata = resp_rdata; last_rd = resp_rd; last_err = resp_err;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] ld_addr [5] = '{32'h21, 32'h23, 32'h23, 32'h22, 32'h22};
  logic [2:0]  ld_f3   [5] = '{F3_B, F3_B, F3_BU, F3_H, F3_HU};
  logic [31:0] ld_exp  [5] = '{32'h0000007F, 32'hFFFFFF80, 32'h00000080, 32'hFFFF80F1, 32'h000080F1};

  initial begin
    bit          we;
    logic [2:0]  f3;
    logic [31:0] a;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0;
    req_wdata = 32'h0; req_rd = 5'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_outs", {mem_addr | mem_wdata}, 32'd0);
    check("rst_mem_be_we", 32'({mem_be, mem_we}), 32'd0);
    check("rst_resp", 32'({resp_valid, resp_err, resp_rd}), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    run_access(1'b1, F3_W, 32'h10, 32'hDEADBEEF, 5'd3, 0, 0);
    @(negedge clk); #1;
    check("sw_be", 32'(last_mbe), 32'hF);
    check("sw_addr", last_maddr, 32'h10);
    check("sw_wdata", last_mwdata, 32'hDEADBEEF);
    check("sw_latency", 32'(last_resp_cyc - acc_cyc - 1), 32'd2);
    check("sw_err", 32'(last_err), 32'd0);

    mem_m[32'h20] = 32'h80F17F02;
    for (int i = 0; i < 5; i++) begin
      run_access(1'b0, ld_f3[i], ld_addr[i], 32'h0, 5'(i + 7), 0, 0);
      @(negedge clk); #1;
      check("ld_data", last_rdata, ld_exp[i]);
      check("ld_rd", 32'(last_rd), 32'(i + 7));
      check("ld_latency", 32'(last_resp_cyc - acc_cyc - 1), 32'd3);
    end

    run_access(1'b1, F3_B, 32'h12, 32'h000000AB, 5'd1, 0, 0);
    @(negedge clk); #1;
    check("sb_be", 32'(last_mbe), 32'h4);
    check("sb_wdata", last_mwdata, 32'hABABABAB);
    run_access(1'b1, F3_H, 32'h12, 32'h00001234, 5'd1, 0, 0);
    @(negedge clk); #1;
    check("sh_be", 32'(last_mbe), 32'hC);
    check("sh_wdata", last_mwdata, 32'h12341234);

    saw_mreq = 1'b0;
    run_access(1'b0, F3_W, 32'h02, 32'h0, 5'd4, 0, 0);
    @(negedge clk); #1;
    check("err_lw_flag", 32'(last_err), 32'd1);
    check("err_lw_latency", 32'(last_resp_cyc - acc_cyc - 1), 32'd1);
    run_access(1'b1, F3_H, 32'h01, 32'h5555, 5'd4, 0, 0);
    @(negedge clk); #1;
    check("err_sh_flag", 32'(last_err), 32'd1);
    run_access(1'b0, 3'b011, 32'h00, 32'h0, 5'd4, 0, 0);
    @(negedge clk); #1;
    check("err_f3_flag", 32'(last_err), 32'd1);
    check("err_no_mem_req", 32'(saw_mreq), 32'd0);

    mem_m[32'h40] = 32'h13579BDF;
    run_access(1'b0, F3_W, 32'h40, 32'h0, 5'd9, 3, 2);
    @(negedge clk); #1;
    check("stall_latency", 32'(last_resp_cyc - acc_cyc - 1), 32'd8);
    check("stall_data", last_rdata, 32'h13579BDF);

    repeat (300) begin
      idle_cycles($urandom_range(0, 2));
      we = 1'($urandom);
      f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom) :
           (we ? 3'($urandom_range(0, 2)) : ($urandom_range(0, 1) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(4, 5))));
      a  = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(32'h100, 32'h13F);
      run_access(we, f3, a, $urandom, 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    idle_cycles(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset while waiting for read data, then a stray rvalid
    chk_en = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h40; req_rd = 5'd6;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    check("pre_rst_busy", 32'({req_ready, mem_req, resp_valid}), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    check("rst_mid_outs", 32'({mem_req, mem_we, mem_be, resp_valid, resp_err, resp_rd}), 32'd0);
    check("rst_mid_data", resp_rdata | mem_addr | mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_idle", 32'({req_ready, mem_req, resp_valid}), 32'b100);
    end
    @(posedge clk); #1;
    chk_en = 1'b1;
    run_access(1'b0, F3_HU, 32'h42, 32'h0, 5'd2, 1, 1);
    @(negedge clk); #1;
    check("recover_data", last_rdata, 32'h00001357);
    idle_cycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
